divider_iter: RTL and testbench
===============================

DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64.
REQ-002 SHALL have parameter EARLY_OUT, default 1; 1 enables the one-cycle path for divide-by-zero and signed overflow.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  request offered.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request.
REQ-007 SHALL have port funct3  input  3  op: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port mul_ext_valid  input  1  instruction belongs to the M extension.
REQ-009 SHALL have ports dividend, divisor  input  XLEN  operands.
REQ-010 SHALL have port div_valid  output  1  combinational: funct3[2] & mul_ext_valid.
REQ-011 SHALL have port resp_valid  output  1  result available.
REQ-012 SHALL have port resp_ready  input  1  consumer takes the result.
REQ-013 SHALL have port result  output  XLEN  quotient or remainder.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC, FIX and DONE.
REQ-016 SHALL drive req_ready = (state==IDLE).
REQ-017 SHALL accept a request when req_valid & req_ready & div_valid.
REQ-018 SHALL ignore req_valid while div_valid=0: no state change, no response.
REQ-019 SHALL capture funct3, operands, the signed flag (~funct3[0]) and the op sign bits on acceptance.
REQ-020 SHALL, for signed ops, divide operand magnitudes; unsigned ops use the operands as-is.
REQ-021 SHALL run a restoring radix-2 divider, one quotient bit per cycle, for exactly XLEN CALC cycles, MSB first.
REQ-022 SHALL use a remainder register XLEN+1 bits wide for the trial subtraction.
REQ-023 SHALL use a counter of $clog2(XLEN)+1 bits that loads XLEN on acceptance and decrements per CALC cycle.
REQ-024 SHALL leave CALC for FIX when the counter reaches 0.
REQ-025 SHALL spend one FIX cycle on sign correction, then go to DONE.
REQ-026 SHALL, in FIX, negate the quotient when signed & (sign(dividend) XOR sign(divisor)) & divisor!=0.
REQ-027 SHALL, in FIX, negate the remainder when signed & sign(dividend).
REQ-028 SHALL select result = quotient for funct3[1]=0 and remainder for funct3[1]=1.
REQ-029 SHALL assert resp_valid exactly in DONE; latency from the acceptance edge is XLEN+2 cycles.
REQ-030 SHALL hold result stable while resp_valid=1 & resp_ready=0.
REQ-031 SHALL, in DONE with resp_ready=1, return to IDLE on the next edge.
REQ-032 SHALL keep req_ready=0 in DONE; there is no back-to-back accept in the DONE cycle.
REQ-033 SHALL, on divide-by-zero, give DIV/DIVU = all ones and REM/REMU = dividend.
REQ-034 SHALL, on signed overflow (dividend = 1 followed by XLEN-1 zeros, divisor = all ones), give DIV = dividend and REM = 0.
REQ-035 SHALL, when EARLY_OUT=1 and a REQ-033/REQ-034 case is detected at acceptance, go IDLE->DONE directly with latency 1.
REQ-036 SHALL, when EARLY_OUT=0, send the REQ-033/REQ-034 cases through CALC/FIX and still produce the REQ-033/REQ-034 values.
REQ-037 SHALL ignore changes on funct3, the operands and mul_ext_valid after acceptance.

Reset
REQ-038 SHALL, while resetn=0, force state=IDLE, resp_valid=0, busy=0, req_ready=1, result=0 and counter=0.
REQ-039 SHALL abort any operation in flight on reset assertion, with no response after release.
REQ-040 SHALL accept a request on the first rising edge after resetn deasserts.

Verification
REQ-041 SHALL be covered by: XLEN=32, DIV, 100 / -7 -> after 34 cycles resp_valid=1, result=0xFFFFFFF2 (-14); same operands with REM -> 0x00000002.
REQ-042 SHALL be covered by: DIVU 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; REMU -> 0x0000000F; both with latency 34.
REQ-043 SHALL be covered by: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; latency 1 with EARLY_OUT=1 and 34 with EARLY_OUT=0.
REQ-044 SHALL be covered by: DIV -5 / 0 -> 0xFFFFFFFF, REM -5 / 0 -> 0xFFFFFFFB; the EARLY_OUT=0 case is checked the same way.
REQ-045 SHALL be covered by: resp_ready held low 5 cycles in DONE -> result and resp_valid stable, req_ready=0; returns to IDLE one edge after resp_ready=1.
REQ-046 SHALL be covered by: funct3=000 or mul_ext_valid=0 with req_valid=1 -> div_valid=0, busy stays 0; resetn pulsed low mid-CALC -> IDLE, no resp_valid.

Source files
------------

// File: rtl/divider_iter.sv
// Iterative restoring radix-2 divider for the RISC-V M-extension DIV/DIVU/REM/REMU ops.
// Produces one quotient bit per cycle, applies sign correction, and holds the result until it is consumed.
`timescale 1ns/1ps
module divider_iter #(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic            mul_ext_valid,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_valid,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg;
  logic [XLEN:0]     rem_reg;
  logic [XLEN-1:0]   quo_reg;
  logic [XLEN-1:0]   dsr_reg;
  logic [XLEN-1:0]   result_reg;
  logic              signed_reg, sign_a_reg, sign_b_reg, zero_reg, rem_sel_reg;

  logic              accept, is_signed, div_zero, overflow, early;
  logic [XLEN-1:0]   mag_a, mag_b, early_result;
  logic [XLEN+1:0]   diff;
  logic              fits;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   q_fix, r_fix;

  assign div_valid = funct3[2] & mul_ext_valid;
  assign accept    = req_valid & req_ready & div_valid;
  assign is_signed = ~funct3[0];

  assign mag_a = (is_signed & dividend[XLEN-1]) ? -dividend : dividend;
  assign mag_b = (is_signed & divisor[XLEN-1])  ? -divisor  : divisor;

  assign div_zero = (divisor == '0);
  assign overflow = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor);
  assign early    = (EARLY_OUT != 0) & (div_zero | overflow);

  // Divide-by-zero returns all ones / the dividend; signed overflow returns the dividend / zero.
  always_comb begin
    early_result = '0;
    if (div_zero)
      early_result = funct3[1] ? dividend : '1;
    else
      early_result = funct3[1] ? '0 : dividend;
  end

  // Trial subtraction on the shifted partial remainder; the extra top bit is the borrow.
  assign diff = {rem_reg, quo_reg[XLEN-1]} - {2'b00, dsr_reg};
  assign fits = ~diff[XLEN+1];

  assign neg_q = signed_reg & (sign_a_reg ^ sign_b_reg) & ~zero_reg;
  assign neg_r = signed_reg & sign_a_reg;
  assign q_fix = neg_q ? -quo_reg : quo_reg;
  assign r_fix = neg_r ? -rem_reg[XLEN-1:0] : rem_reg[XLEN-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (accept)
          state_next = early ? DONE : CALC;
      end
      CALC: begin
        if (count_reg == CW'(1))
          state_next = FIX;
      end
      FIX: begin
        state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg   <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dsr_reg     <= '0;
      result_reg  <= '0;
      signed_reg  <= 1'b0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      zero_reg    <= 1'b0;
      rem_sel_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            count_reg   <= CW'(XLEN);
            rem_reg     <= '0;
            quo_reg     <= mag_a;
            dsr_reg     <= mag_b;
            signed_reg  <= is_signed;
            sign_a_reg  <= dividend[XLEN-1];
            sign_b_reg  <= divisor[XLEN-1];
            zero_reg    <= div_zero;
            rem_sel_reg <= funct3[1];
            if (early)
              result_reg <= early_result;
          end
        end
        CALC: begin
          count_reg <= count_reg - CW'(1);
          rem_reg   <= fits ? diff[XLEN:0] : {rem_reg[XLEN-1:0], quo_reg[XLEN-1]};
          quo_reg   <= {quo_reg[XLEN-2:0], fits};
        end
        FIX: begin
          result_reg <= rem_sel_reg ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;

endmodule

// File: tb/tb_divider_iter.sv
// Directed bench for divider_iter: one early-out instance and one without, sharing clock, reset and operands.
`timescale 1ns/1ps
module tb_divider_iter;

  logic        clk;
  logic        resetn;
  logic [2:0]  funct3;
  logic        mul_ext_valid;
  logic [31:0] dividend, divisor;

  logic        req_valid_1, req_ready_1, div_valid_1, resp_valid_1, resp_ready_1, busy_1;
  logic [31:0] result_1;
  logic        req_valid_0, req_ready_0, div_valid_0, resp_valid_0, resp_ready_0, busy_0;
  logic [31:0] result_0;

  int total = 0;
  int bad   = 0;

  divider_iter #(.XLEN(32), .EARLY_OUT(1)) u_e1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid_1), .req_ready(req_ready_1),
    .funct3(funct3), .mul_ext_valid(mul_ext_valid), .dividend(dividend), .divisor(divisor),
    .div_valid(div_valid_1), .resp_valid(resp_valid_1), .resp_ready(resp_ready_1),
    .result(result_1), .busy(busy_1)
  );

  divider_iter #(.XLEN(32), .EARLY_OUT(0)) u_e0 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid_0), .req_ready(req_ready_0),
    .funct3(funct3), .mul_ext_valid(mul_ext_valid), .dividend(dividend), .divisor(divisor),
    .div_valid(div_valid_0), .resp_valid(resp_valid_0), .resp_ready(resp_ready_0),
    .result(result_0), .busy(busy_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sel=1 drives the early-out instance, sel=0 the other one.
  task automatic run_op(input bit sel, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat, input bit hold, input string tag);
    int   lat;
    logic rv;
    @(posedge clk); #1;
    funct3 = f3; mul_ext_valid = 1'b1; dividend = a; divisor = b;
    if (sel) req_valid_1 = 1'b1; else req_valid_0 = 1'b1;
    @(posedge clk); #1;
    req_valid_1 = 1'b0; req_valid_0 = 1'b0;
    dividend = $urandom; divisor = $urandom; funct3 = 3'b000;
    lat = 1;
    rv  = sel ? resp_valid_1 : resp_valid_0;
    while (!rv && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      rv = sel ? resp_valid_1 : resp_valid_0;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(sel ? result_1 : result_0), 64'(exp_res));
    $display("op %s: f3=%b a=%h b=%h result=%h lat=%0d", tag, f3, a, b, sel ? result_1 : result_0, lat);
    if (!hold) begin
      @(posedge clk); #1;
      check({tag, "_idle"}, 64'(sel ? req_ready_1 : req_ready_0), 64'd1);
    end
  endtask

  initial begin
    bit seen;
    resetn = 1'b0; funct3 = 3'b000; mul_ext_valid = 1'b0; dividend = '0; divisor = '0;
    req_valid_1 = 1'b0; req_valid_0 = 1'b0; resp_ready_1 = 1'b1; resp_ready_0 = 1'b1;

    #2;
    check("rst_req_ready", 64'(req_ready_1), 64'd1);
    check("rst_busy", 64'(busy_1), 64'd0);
    check("rst_resp_valid", 64'(resp_valid_1), 64'd0);
    check("rst_result", 64'(result_1), 64'd0);
    check("rst_count", 64'(u_e1.count_reg), 64'd0);
    check("rst_req_ready_e0", 64'(req_ready_0), 64'd1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    run_op(1, 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34, 0, "div_100_m7");
    run_op(1, 3'b110, 32'd100, 32'hFFFFFFF9, 32'h00000002, 34, 0, "rem_100_m7");
    run_op(0, 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34, 0, "div_100_m7_e0");
    run_op(1, 3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, 0, "div_m100_7");
    run_op(1, 3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34, 0, "rem_m100_7");
    run_op(1, 3'b101, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 34, 0, "divu_ffff_10");
    run_op(1, 3'b111, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 34, 0, "remu_ffff_10");
    run_op(0, 3'b101, 32'h12345678, 32'h100, 32'h00123456, 34, 0, "divu_e0");
    run_op(0, 3'b111, 32'h12345678, 32'h100, 32'h00000078, 34, 0, "remu_e0");
    run_op(1, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 0, "divu_no_ovf");

    run_op(1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "ovf_div_e1");
    run_op(1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 0, "ovf_rem_e1");
    run_op(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, 0, "ovf_div_e0");
    run_op(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, 0, "ovf_rem_e0");

    run_op(1, 3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 1, 0, "dz_div_e1");
    run_op(1, 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1, 0, "dz_rem_e1");
    run_op(0, 3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 34, 0, "dz_div_e0");
    run_op(0, 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 34, 0, "dz_rem_e0");
    run_op(1, 3'b101, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1, 0, "dz_divu_e1");
    run_op(1, 3'b111, 32'd7, 32'd0, 32'h00000007, 1, 0, "dz_remu_e1");

    // Consumer stalls for five cycles in DONE.
    resp_ready_1 = 1'b0;
    run_op(1, 3'b110, 32'd100, 32'hFFFFFFF9, 32'h00000002, 34, 1, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_resp_valid", 64'(resp_valid_1), 64'd1);
      check("hold_result", 64'(result_1), 64'h2);
      check("hold_req_ready", 64'(req_ready_1), 64'd0);
    end
    resp_ready_1 = 1'b1;
    @(posedge clk); #1;
    check("release_resp_valid", 64'(resp_valid_1), 64'd0);
    check("release_req_ready", 64'(req_ready_1), 64'd1);
    $display("op hold: released after 5 stalled cycles");

    // Requests without div_valid are ignored.
    @(posedge clk); #1;
    funct3 = 3'b000; mul_ext_valid = 1'b1; dividend = 32'd10; divisor = 32'd3; req_valid_1 = 1'b1;
    #1 check("nodiv_f3_div_valid", 64'(div_valid_1), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("nodiv_f3_busy", 64'(busy_1), 64'd0);
    check("nodiv_f3_resp", 64'(resp_valid_1), 64'd0);
    funct3 = 3'b100; mul_ext_valid = 1'b0;
    #1 check("nodiv_mext_div_valid", 64'(div_valid_1), 64'd0);
    repeat (3) @(posedge clk); #1;
    check("nodiv_mext_busy", 64'(busy_1), 64'd0);
    req_valid_1 = 1'b0; mul_ext_valid = 1'b1;
    $display("op ignore: req_valid without div_valid left unit idle");

    // Reset in the middle of CALC aborts without a response.
    @(posedge clk); #1;
    funct3 = 3'b100; dividend = 32'd100; divisor = 32'd7; req_valid_0 = 1'b1;
    @(posedge clk); #1;
    req_valid_0 = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("mid_calc_busy", 64'(busy_0), 64'd1);
    resetn = 1'b0;
    #1;
    check("abort_busy", 64'(busy_0), 64'd0);
    check("abort_req_ready", 64'(req_ready_0), 64'd1);
    check("abort_resp_valid", 64'(resp_valid_0), 64'd0);
    check("abort_result", 64'(result_0), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid_0) seen = 1'b1;
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    $display("op abort: reset mid-CALC, resp seen=%0d", seen);

    // Request held across reset release is taken on the first edge.
    @(posedge clk); #1;
    resetn = 1'b0;
    funct3 = 3'b100; mul_ext_valid = 1'b1; dividend = 32'd100; divisor = 32'hFFFFFFF9; req_valid_1 = 1'b1;
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    check("first_edge_busy", 64'(busy_1), 64'd1);
    repeat (32) @(posedge clk); #1;
    check("first_edge_not_yet", 64'(resp_valid_1), 64'd0);
    @(posedge clk); #1;
    check("first_edge_resp", 64'(resp_valid_1), 64'd1);
    check("first_edge_result", 64'(result_1), 64'hFFFFFFF2);
    $display("op first_edge: result=%h", result_1);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
